// File: rtl/goertzel_pkg.sv
// Shared definitions for the Goertzel post-processing chain and the debug display.
package goertzel_pkg;

   localparam int unsigned MAG_W_DEFAULT      = 16;
   localparam int unsigned AVG_LOG2_DEFAULT   = 2;
   localparam int unsigned HOLD_COUNT_DEFAULT = 3;

   // Detection thresholds, also read by the top-level LED bar display.
   localparam logic [15:0] ON_THRESH_DEFAULT  = 16'h0800;
   localparam logic [15:0] OFF_THRESH_DEFAULT = 16'h0400;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ARMING    = 2'd1,
      ACTIVE    = 2'd2,
      RELEASING = 2'd3
   } det_state_t;

endpackage

// File: rtl/block_averager.sv
// Sums 2**AVG_LOG2 consecutive magnitudes and emits their floor average with a one-cycle pulse.
module block_averager
   import goertzel_pkg::*;
#(
   parameter int unsigned MAG_W    = MAG_W_DEFAULT,
   parameter int unsigned AVG_LOG2 = AVG_LOG2_DEFAULT
) (
   input  logic             sys_clk,
   input  logic             rst,
   input  logic             mag_valid,
   input  logic [MAG_W-1:0] mag,
   output logic [MAG_W-1:0] avg_mag,
   output logic             avg_valid
);

   // Wide enough to hold N full-scale samples, so the sum never wraps.
   localparam int unsigned ACC_W = MAG_W + AVG_LOG2;
   // One spare bit so the counter is never zero-width when AVG_LOG2 = 0.
   localparam int unsigned CNT_W = AVG_LOG2 + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [MAG_W-1:0] avg_q, avg_d;
   logic             avg_valid_d;
   logic             avg_valid_q;
   logic [ACC_W-1:0] sum;

   assign sum = acc_q + ACC_W'(mag);

   // Accumulate; on the last sample of a frame publish the average and restart from zero.
   always_comb begin
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      avg_d       = avg_q;
      avg_valid_d = 1'b0;
      if (mag_valid) begin
         if (cnt_q == LAST_CNT) begin
            avg_d       = sum[ACC_W-1:AVG_LOG2];
            avg_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
         end else begin
            acc_d = sum;
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // State registers; reset discards any partial frame.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         avg_q       <= '0;
         avg_valid_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         avg_q       <= avg_d;
         avg_valid_q <= avg_valid_d;
      end
   end

   assign avg_mag   = avg_q;
   assign avg_valid = avg_valid_q;

endmodule

// File: rtl/goertzel_tone_detect.sv
// Frame-averaged, hysteretic tone detector with raw-magnitude peak-hold for the debug display.
module goertzel_tone_detect
   import goertzel_pkg::*;
#(
   parameter int unsigned          MAG_W      = MAG_W_DEFAULT,
   parameter int unsigned          AVG_LOG2   = AVG_LOG2_DEFAULT,
   parameter logic [MAG_W-1:0]     ON_THRESH  = MAG_W'(ON_THRESH_DEFAULT),
   parameter logic [MAG_W-1:0]     OFF_THRESH = MAG_W'(OFF_THRESH_DEFAULT),
   parameter int unsigned          HOLD_COUNT = HOLD_COUNT_DEFAULT
) (
   input  logic             sys_clk,
   input  logic             rst,
   input  logic             mag_valid,
   input  logic [MAG_W-1:0] mag,
   input  logic             peak_clear,
   output logic [MAG_W-1:0] avg_mag,
   output logic             avg_valid,
   output logic             tone_detect,
   output logic             detect_rise,
   output logic             detect_fall,
   output logic [MAG_W-1:0] peak_mag
);

   localparam int unsigned CNT_W = $clog2(HOLD_COUNT + 1);
   localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_COUNT);

   det_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tone_q, tone_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic [MAG_W-1:0] peak_q, peak_d;
   logic [CNT_W-1:0] cnt_inc;

   block_averager #(
      .MAG_W    (MAG_W),
      .AVG_LOG2 (AVG_LOG2)
   ) u_block_averager (
      .sys_clk   (sys_clk),
      .rst       (rst),
      .mag_valid (mag_valid),
      .mag       (mag),
      .avg_mag   (avg_mag),
      .avg_valid (avg_valid)
   );

   assign cnt_inc = cnt_q + CNT_W'(1);

   // Hysteresis FSM: only advances on a fresh frame average.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (avg_valid) begin
         unique case (state_q)
            IDLE: begin
               if (avg_mag >= ON_THRESH) begin
                  state_d = ARMING;
                  cnt_d   = CNT_W'(1);
               end
            end
            ARMING: begin
               if (avg_mag >= ON_THRESH) begin
                  if (cnt_inc == HOLD_CNT) begin
                     state_d = ACTIVE;
                     cnt_d   = '0;
                     rise_d  = 1'b1;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
            ACTIVE: begin
               if (avg_mag < OFF_THRESH) begin
                  state_d = RELEASING;
                  cnt_d   = CNT_W'(1);
               end
            end
            RELEASING: begin
               if (avg_mag < OFF_THRESH) begin
                  if (cnt_inc == HOLD_CNT) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                     fall_d  = 1'b1;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  state_d = ACTIVE;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
      tone_d = (state_d == ACTIVE) || (state_d == RELEASING);
   end

   // Peak-hold; a clear coinciding with a sample restarts the hold from that sample.
   always_comb begin
      peak_d = peak_q;
      if (peak_clear) begin
         peak_d = mag_valid ? mag : '0;
      end else if (mag_valid && (mag > peak_q)) begin
         peak_d = mag;
      end
   end

   // State and registered outputs.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tone_q  <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         peak_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tone_q  <= tone_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         peak_q  <= peak_d;
      end
   end

   assign tone_detect = tone_q;
   assign detect_rise = rise_q;
   assign detect_fall = fall_q;
   assign peak_mag    = peak_q;

endmodule
